// File: rtl/pipe_pkg.sv
// pipe_pkg
// Shared types and constants for the handshaked pipeline stage register.
//   pipe_state_t : occupancy state of a stage (EMPTY, ONE, FULL); the
//                  encoding doubles as the held-entry count.
//   PIPE_CNT_W   : width of the optional statistics counters.
package pipe_pkg;

  localparam int PIPE_CNT_W = 32;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } pipe_state_t;

endpackage

// File: rtl/pipe_sat_counter.sv
// pipe_sat_counter
// Event counter that sticks at its all-ones value instead of wrapping.
// Ports:
//   CLK   in   clock, rising edge
//   RST   in   synchronous active-high clear
//   inc   in   count this cycle
//   count out  W-bit running count, saturating at all ones
module pipe_sat_counter
  import pipe_pkg::*;
#(
  parameter int W = PIPE_CNT_W
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         inc,
  output logic [W-1:0] count
);

  // Only RST clears the count; once all ones it stays there so a long run
  // never reports a misleadingly small value.
  always_ff @(posedge CLK) begin
    if (RST) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg
// Handshaked pipeline stage register placed between CPU pipeline stages.
// Carries an opaque payload with ready/valid in both directions, supports
// synchronous flush (stage becomes a bubble) and an optional two-entry skid
// mode (SKID=1) whose in_ready is a pure flop decode.
// Optional statistics counters are built when PIPE_STAGE_STATS_EN is defined.
// Ports:
//   CLK        in   clock, rising edge
//   RST        in   synchronous active-high reset
//   flush      in   drop held entries and the current input
//   in_valid   in   upstream presents in_data
//   in_ready   out  stage accepts input this cycle
//   in_data    in   upstream payload
//   out_valid  out  out_data is a real instruction
//   out_ready  in   downstream consumes the output this cycle
//   out_data   out  registered payload, RESET_VAL when empty
//   occupancy  out  number of held entries (0..2)
//   stall_cnt  out  cycles with out_valid & ~out_ready (stats build only)
//   bubble_cnt out  cycles with ~out_valid outside reset (stats build only)
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int              DATA_W    = 32,
  parameter bit              SKID      = 1'b1,
  parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
`ifdef PIPE_STAGE_STATS_EN
  ,
  output logic [PIPE_CNT_W-1:0] stall_cnt,
  output logic [PIPE_CNT_W-1:0] bubble_cnt
`endif
);

  pipe_state_t       state;
  logic [DATA_W-1:0] mData;
  logic [DATA_W-1:0] sData;
  logic              accept;
  logic              consume;

  assign out_valid = (state != EMPTY);
  assign consume   = out_valid & out_ready;
  assign accept    = in_valid & in_ready;
  assign occupancy = state;

  // Empty stage always presents RESET_VAL so bubbles never carry stale bits.
  assign out_data = (state == EMPTY) ? RESET_VAL : mData;

  // Skid mode decodes in_ready straight from the state flops, cutting the
  // combinational path from out_ready; plain mode passes the stall through.
  // in_ready is deliberately not gated by flush.
  if (SKID) begin : g_skid_ready
    assign in_ready = (state != FULL);
  end else begin : g_plain_ready
    assign in_ready = ~out_valid | out_ready;
  end

  // Flush shares the reset path: both empty the stage and drop the input.
  // M always drives the outputs; S only catches the one beat that arrives
  // while downstream stalls, and is promoted into M when M drains.
  always_ff @(posedge CLK) begin
    if (RST || flush) begin
      state <= EMPTY;
      mData <= RESET_VAL;
      sData <= RESET_VAL;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            state <= ONE;
            mData <= in_data;
          end
        end
        ONE: begin
          if (accept && consume) begin
            mData <= in_data;
          end else if (consume) begin
            state <= EMPTY;
            mData <= RESET_VAL;
          end else if (accept && SKID) begin
            state <= FULL;
            sData <= in_data;
          end
        end
        FULL: begin
          if (consume) begin
            state <= ONE;
            mData <= sData;
            sData <= RESET_VAL;
          end
        end
        default: begin
          state <= EMPTY;
          mData <= RESET_VAL;
          sData <= RESET_VAL;
        end
      endcase
    end
  end

`ifdef PIPE_STAGE_STATS_EN
  // Counters observe the handshake only; flush leaves them untouched.
  pipe_sat_counter #(.W(PIPE_CNT_W)) u_stall_cnt (
    .CLK   (CLK),
    .RST   (RST),
    .inc   (out_valid & ~out_ready),
    .count (stall_cnt)
  );

  pipe_sat_counter #(.W(PIPE_CNT_W)) u_bubble_cnt (
    .CLK   (CLK),
    .RST   (RST),
    .inc   (~out_valid & ~RST),
    .count (bubble_cnt)
  );
`else
  // Statistics build disabled: no counter ports or logic.
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg
// Scoreboarded bench for pipe_stage_reg: one SKID=1 instance (RESET_VAL
// 32'hDEAD_BEEF) and one SKID=0 instance (RESET_VAL 0). Stimulus pushes the
// payloads that will be accepted; monitors pop and compare on each consume.
// Statistics checks are built when PIPE_STAGE_STATS_EN is defined.
module tb_pipe_stage_reg;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1;

  // sk* : SKID=1 instance, rg* : SKID=0 instance
  logic        skFlush = 0, skInValid = 0, skOutReady = 0;
  logic        skInReady, skOutValid;
  logic [31:0] skInData = '0, skOutData;
  logic [1:0]  skOcc;
  logic        rgFlush = 0, rgInValid = 0, rgOutReady = 0;
  logic        rgInReady, rgOutValid;
  logic [31:0] rgInData = '0, rgOutData;
  logic [1:0]  rgOcc;
`ifdef PIPE_STAGE_STATS_EN
  logic [31:0] skStall, skBubble, rgStall, rgBubble;
`endif

  logic [31:0] skQ[$];
  logic [31:0] rgQ[$];
  int passCnt  = 0;
  int totalCnt = 0;

  pipe_stage_reg #(.DATA_W(32), .SKID(1'b1), .RESET_VAL(32'hDEAD_BEEF)) dut1 (
    .CLK(clk), .RST(rst), .flush(skFlush),
    .in_valid(skInValid), .in_ready(skInReady), .in_data(skInData),
    .out_valid(skOutValid), .out_ready(skOutReady), .out_data(skOutData),
    .occupancy(skOcc)
`ifdef PIPE_STAGE_STATS_EN
    , .stall_cnt(skStall), .bubble_cnt(skBubble)
`endif
  );

  pipe_stage_reg #(.DATA_W(32), .SKID(1'b0), .RESET_VAL(32'h0)) dut0 (
    .CLK(clk), .RST(rst), .flush(rgFlush),
    .in_valid(rgInValid), .in_ready(rgInReady), .in_data(rgInData),
    .out_valid(rgOutValid), .out_ready(rgOutReady), .out_data(rgOutData),
    .occupancy(rgOcc)
`ifdef PIPE_STAGE_STATS_EN
    , .stall_cnt(rgStall), .bubble_cnt(rgBubble)
`endif
  );

  // Single point where every comparison is counted and reported.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    totalCnt++;
    if (actual === expected) passCnt++;
    else $display("[TB] FAIL %s: got 0x%08h, want 0x%08h", name, actual, expected);
  endtask

  task automatic idleAll();
    skInValid = 0; skInData = '0; skOutReady = 0; skFlush = 0;
    rgInValid = 0; rgInData = '0; rgOutReady = 0; rgFlush = 0;
  endtask

  // Drives one cycle of inputs on instance m (1 = skid, 0 = plain), checks
  // the pre-edge handshake state and records what the stage should accept.
  task automatic applyStimulus(input int m, input logic vld, input logic [31:0] data,
                               input logic ordy, input logic fl, input logic expReady,
                               input logic expValid, input logic [1:0] expOcc);
    @(posedge clk);
    #1;
    if (m == 1) begin
      skInValid = vld; skInData = data; skOutReady = ordy; skFlush = fl;
    end else begin
      rgInValid = vld; rgInData = data; rgOutReady = ordy; rgFlush = fl;
    end
    #1;
    if (m == 1) begin
      checkOutput("sk in_ready", {31'b0, skInReady}, {31'b0, expReady});
      checkOutput("sk out_valid", {31'b0, skOutValid}, {31'b0, expValid});
      checkOutput("sk occupancy", {30'b0, skOcc}, {30'b0, expOcc});
      if (fl) skQ.delete();
      else if (vld && expReady) skQ.push_back(data);
    end else begin
      checkOutput("rg in_ready", {31'b0, rgInReady}, {31'b0, expReady});
      checkOutput("rg out_valid", {31'b0, rgOutValid}, {31'b0, expValid});
      checkOutput("rg occupancy", {30'b0, rgOcc}, {30'b0, expOcc});
      if (fl) rgQ.delete();
      else if (vld && expReady) rgQ.push_back(data);
    end
  endtask

  // Pops and compares on every consume; checks bubbles carry RESET_VAL.
  task automatic monitorStep(input int m);
    logic [31:0] exp;
    if (m == 1) begin
      if (!rst && !skFlush && skOutValid && skOutReady) begin
        if (skQ.size() == 0) begin
          totalCnt++;
          $display("[TB] FAIL sk unexpected output: got 0x%08h, want none", skOutData);
        end else begin
          exp = skQ.pop_front();
          checkOutput("sk out_data", skOutData, exp);
        end
      end
      if (!rst && !skOutValid) checkOutput("sk bubble data", skOutData, 32'hDEAD_BEEF);
    end else begin
      if (!rst && !rgFlush && rgOutValid && rgOutReady) begin
        if (rgQ.size() == 0) begin
          totalCnt++;
          $display("[TB] FAIL rg unexpected output: got 0x%08h, want none", rgOutData);
        end else begin
          exp = rgQ.pop_front();
          checkOutput("rg out_data", rgOutData, exp);
        end
      end
      if (!rst && !rgOutValid) checkOutput("rg bubble data", rgOutData, 32'h0);
    end
  endtask

  always @(negedge clk) monitorStep(1);
  always @(negedge clk) monitorStep(0);

  task automatic doReset();
    @(posedge clk);
    #1;
    rst = 1;
    idleAll();
    skQ.delete();
    rgQ.delete();
    @(posedge clk);
    #1;
    rst = 0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, want $finish before 200000");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main directed sequence.
  initial begin
`ifdef PIPE_STAGE_STATS_EN
    logic [31:0] bubble0;
`endif
    idleAll();
    doReset();

    // Reset/idle state for both instances.
    applyStimulus(1, 0, 32'h0, 0, 0, 1, 0, 2'd0);
    applyStimulus(0, 0, 32'h0, 0, 0, 1, 0, 2'd0);
    checkOutput("sk reset out_data", skOutData, 32'hDEAD_BEEF);

    // SKID=1 stream 1,2,3 at full throughput.
    applyStimulus(1, 1, 32'h1, 1, 0, 1, 0, 2'd0);
    applyStimulus(1, 1, 32'h2, 1, 0, 1, 1, 2'd1);
    applyStimulus(1, 1, 32'h3, 1, 0, 1, 1, 2'd1);
    applyStimulus(1, 0, 32'h0, 1, 0, 1, 1, 2'd1);
    applyStimulus(1, 0, 32'h0, 0, 0, 1, 0, 2'd0);

    // SKID=1 fill the skid entry, blocked input, then drain A then B.
    applyStimulus(1, 1, 32'hA, 0, 0, 1, 0, 2'd0);
    applyStimulus(1, 1, 32'hB, 0, 0, 1, 1, 2'd1);
    applyStimulus(1, 1, 32'hC, 0, 0, 0, 1, 2'd2);
    applyStimulus(1, 0, 32'h0, 1, 0, 0, 1, 2'd2);
    applyStimulus(1, 0, 32'h0, 1, 0, 1, 1, 2'd1);
    applyStimulus(1, 0, 32'h0, 0, 0, 1, 0, 2'd0);

    // SKID=1 flush from FULL with valid input 0xC.
    applyStimulus(1, 1, 32'h11, 0, 0, 1, 0, 2'd0);
    applyStimulus(1, 1, 32'h22, 0, 0, 1, 1, 2'd1);
    applyStimulus(1, 1, 32'hC, 0, 1, 0, 1, 2'd2);
    applyStimulus(1, 0, 32'h0, 1, 0, 1, 0, 2'd0);
    checkOutput("sk flush out_data", skOutData, 32'hDEAD_BEEF);

    // SKID=1 accept, consume and flush together in ONE.
    applyStimulus(1, 1, 32'h33, 0, 0, 1, 0, 2'd0);
    applyStimulus(1, 1, 32'h44, 1, 1, 1, 1, 2'd1);
    applyStimulus(1, 0, 32'h0, 1, 0, 1, 0, 2'd0);

    // SKID=1 reset mid-operation with input and consume active.
    applyStimulus(1, 1, 32'h55, 0, 0, 1, 0, 2'd0);
    @(posedge clk);
    #1;
    rst = 1; skInValid = 1; skInData = 32'h66; skOutReady = 1; skFlush = 0;
    skQ.delete();
    @(posedge clk);
    #1;
    rst = 0;
    idleAll();
    applyStimulus(1, 0, 32'h0, 0, 0, 1, 0, 2'd0);

    // SKID=0 backpressure: in_ready follows out_ready in the same cycle.
    applyStimulus(0, 1, 32'hA, 1, 0, 1, 0, 2'd0);
    applyStimulus(0, 1, 32'hB, 0, 0, 0, 1, 2'd1);
    applyStimulus(0, 1, 32'hB, 0, 0, 0, 1, 2'd1);
    checkOutput("rg held data", rgOutData, 32'hA);
    applyStimulus(0, 1, 32'hB, 1, 0, 1, 1, 2'd1);
    applyStimulus(0, 0, 32'h0, 1, 0, 1, 1, 2'd1);
    applyStimulus(0, 0, 32'h0, 0, 0, 1, 0, 2'd0);

    // SKID=0 stream 1,2,3.
    applyStimulus(0, 1, 32'h1, 1, 0, 1, 0, 2'd0);
    applyStimulus(0, 1, 32'h2, 1, 0, 1, 1, 2'd1);
    applyStimulus(0, 1, 32'h3, 1, 0, 1, 1, 2'd1);
    applyStimulus(0, 0, 32'h0, 1, 0, 1, 1, 2'd1);
    applyStimulus(0, 0, 32'h0, 0, 0, 1, 0, 2'd0);

    // SKID=0 flush while held and stalled, input 0xC dropped.
    applyStimulus(0, 1, 32'h77, 0, 0, 1, 0, 2'd0);
    applyStimulus(0, 1, 32'hC, 0, 1, 0, 1, 2'd1);
    applyStimulus(0, 0, 32'h0, 1, 0, 1, 0, 2'd0);
    applyStimulus(0, 0, 32'h0, 0, 0, 1, 0, 2'd0);

`ifdef PIPE_STAGE_STATS_EN
    // Five stalled cycles, then three empty cycles.
    doReset();
    applyStimulus(1, 1, 32'h88, 0, 0, 1, 0, 2'd0);
    repeat (5) applyStimulus(1, 0, 32'h0, 0, 0, 1, 1, 2'd1);
    applyStimulus(1, 0, 32'h0, 1, 0, 1, 1, 2'd1);
    @(posedge clk);
    #1;
    idleAll();
    bubble0 = skBubble;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("sk stall_cnt", skStall, 32'd5);
    checkOutput("sk bubble_cnt delta", skBubble - bubble0, 32'd3);

    // Saturation: preload all ones and stall once more.
    applyStimulus(1, 1, 32'h99, 0, 0, 1, 0, 2'd0);
    @(posedge clk);
    #1;
    skInValid = 0;
    force dut1.u_stall_cnt.count = 32'hFFFF_FFFF;
    @(posedge clk);
    #1;
    release dut1.u_stall_cnt.count;
    @(posedge clk);
    #1;
    checkOutput("sk stall_cnt saturated", skStall, 32'hFFFF_FFFF);
    applyStimulus(1, 0, 32'h0, 1, 0, 1, 1, 2'd1);
    applyStimulus(1, 0, 32'h0, 0, 0, 1, 0, 2'd0);
`endif

    repeat (2) @(posedge clk);
    #1;
    checkOutput("sk queue drained", 32'(skQ.size()), 32'd0);
    checkOutput("rg queue drained", 32'(rgQ.size()), 32'd0);

    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
